serial_mag_compare_ctrl: RTL and testbench
==========================================

SERIAL_MAG_COMPARE_CTRL -- requirements
Module: serial_mag_compare_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; SHALL be even and at least 2.
REQ-002 Derived constant: N = WIDTH/2, the number of 2-bit digits per operand.
REQ-003 Port: clk, input, 1, single clock; all state SHALL change on its rising edge.
REQ-004 Port: rst, input, 1, reset; SHALL be asynchronous and active-high.
REQ-005 Port: start, input, 1, comparison request; SHALL be sampled only in IDLE.
REQ-006 Port: op_a, input, WIDTH, operand A; SHALL be captured when start is accepted.
REQ-007 Port: op_b, input, WIDTH, operand B; SHALL be captured when start is accepted.
REQ-008 Port: busy, output, 1, high while in SCAN.
REQ-009 Port: done, output, 1, single-cycle pulse; SHALL be high only in DONE.
REQ-010 Port: equal, output, 1, registered result flag for A == B.
REQ-011 Port: greater, output, 1, registered result flag for A > B.
REQ-012 Port: less, output, 1, registered result flag for A < B.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-014 IDLE with start=1 SHALL latch op_a/op_b, set digit index to N-1, and go to SCAN.
REQ-015 Each SCAN cycle SHALL present digit [2i+1:2i] of both latched operands to one 2-bit comparator slice.
REQ-016 The first unequal digit, scanning MSB-first, SHALL decide the result: greater if the A digit > B digit, else less.
REQ-017 If all N digits are equal, the result SHALL be equal.
REQ-018 SCAN SHALL decrement the index each cycle and go to DONE after digit 0, so that done is high in cycle k+N+1 for start sampled at edge k.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; start SHALL NOT be accepted in the DONE cycle.
REQ-020 equal/greater/less SHALL update only on entry to DONE, SHALL be one-hot thereafter, and SHALL hold until the next DONE.
REQ-021 start in SCAN or DONE SHALL be ignored; op_a/op_b changes after acceptance SHALL NOT affect the result.
REQ-022 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, with busy=0, done=0, equal=0, greater=0, less=0, index=0 and the latched operands cleared.
REQ-024 Reset mid-SCAN SHALL abort the comparison without a done pulse; the first start after deassertion SHALL run a fresh compare.

Configuration
REQ-025 Macro SERIAL_CMP_EARLY_EXIT_EN: when defined, SCAN SHALL go to DONE in the cycle after the first unequal digit, giving latency j+2 where j is that digit's scan position (0 = MSB).
REQ-026 Without SERIAL_CMP_EARLY_EXIT_EN, SCAN SHALL always visit all N digits, giving a fixed latency of N+1; the results SHALL be identical in both builds.

Structure
REQ-027 Package serial_cmp_pkg SHALL hold the state enum (IDLE/SCAN/DONE) and result encoding constants.
REQ-028 Exactly one sub-module SHALL be used: comparator_2bit (ports a, b, equal, greater, less), instantiated once as the digit slice.
REQ-029 Index and first-difference tracking SHALL be in the controller; no second comparator instance SHALL exist.

Verification (WIDTH=8, N=4)
REQ-030 op_a=0xA5, op_b=0xA5, start pulse -> equal=1, greater=0, less=0; done exactly 5 cycles after start in both builds.
REQ-031 op_a=0x80, op_b=0x7F -> greater=1; done at +2 cycles with SERIAL_CMP_EARLY_EXIT_EN, at +5 cycles without.
REQ-032 op_a=0x12, op_b=0x13 -> less=1; done at +5 cycles in both builds, because the last digit decides.
REQ-033 start re-pulsed with op_a=0x00, op_b=0xFF during SCAN of the 0xA5/0xA5 compare -> ignored; result equal=1 with one done pulse.
REQ-034 rst asserted at cycle +2 of a compare -> all outputs 0 at once, no done pulse; the next compare 0x03 vs 0x01 yields greater=1.
REQ-035 start held high for three consecutive compares (0x10/0x20, 0x20/0x10, 0x33/0x33) -> less, greater, equal, with exactly one IDLE cycle between each done and the next busy.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot result encoding, ordered {less, greater, equal}.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b100;

endpackage

// File: rtl/comparator_2bit.sv
// Combinational 2-bit magnitude comparator used as the per-digit slice.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       equal,
    output logic       greater,
    output logic       less
);

    assign equal   = (a == b);
    assign greater = (a > b);
    assign less    = (a < b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial MSB-first magnitude comparator, one 2-bit digit per cycle.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish right after the first differing digit.
module serial_mag_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_diff;
    logic [2:0]       r_result;

    logic [1:0]       w_dig_a;
    logic [1:0]       w_dig_b;
    logic             w_dig_eq;
    logic             w_dig_gt;
    logic             w_dig_lt;
    logic             w_last;
    logic             w_finish;
    logic [1:0]       w_diff_next;
    logic [2:0]       w_result;

    assign w_dig_a = r_a[{r_idx, 1'b0} +: 2];
    assign w_dig_b = r_b[{r_idx, 1'b0} +: 2];

    comparator_2bit u_digit (
        .a       (w_dig_a),
        .b       (w_dig_b),
        .equal   (w_dig_eq),
        .greater (w_dig_gt),
        .less    (w_dig_lt)
    );

    // r_diff holds {gt, lt} of the first differing digit; once set it is sticky.
    assign w_last      = (r_idx == '0);
    assign w_diff_next = (r_diff != 2'b00) ? r_diff :
                         (w_dig_eq ? 2'b00 : {w_dig_gt, w_dig_lt});

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign w_finish = w_last || !w_dig_eq;
`else
    assign w_finish = w_last;
`endif

    always_comb begin
        w_result = RES_EQ;
        if (w_diff_next[1]) begin
            w_result = RES_GT;
        end else if (w_diff_next[0]) begin
            w_result = RES_LT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SCAN;
            SCAN:    if (w_finish) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_diff   <= 2'b00;
            r_result <= RES_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a    <= op_a;
                        r_b    <= op_b;
                        r_idx  <= IDX_LAST;
                        r_diff <= 2'b00;
                    end
                end
                SCAN: begin
                    r_diff <= w_diff_next;
                    if (!w_last) begin
                        r_idx <= r_idx - IDX_ONE;
                    end
                    if (w_finish) begin
                        r_result <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == SCAN);
    assign done = (r_state == DONE);
    assign {less, greater, equal} = r_result;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench for serial_mag_compare_ctrl; honours SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_mag_compare_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    typedef struct {
        logic [2:0] res;
        int         accept;
        int         doneEdge;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] opA   = '0;
    logic [WIDTH-1:0] opB   = '0;
    logic             busy;
    logic             done;
    logic             equal;
    logic             greater;
    logic             less;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    exp_t       sb[$];
    logic [2:0] expHeld  = 3'b000;

    serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (opA),
        .op_b    (opB),
        .busy    (busy),
        .done    (done),
        .equal   (equal),
        .greater (greater),
        .less    (less)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] refResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a == b) return 3'b001;
        if (a > b)  return 3'b010;
        return 3'b100;
    endfunction

    function automatic int expLatency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int j = 0; j < N; j++) begin
            int p;
            p = 4 ** (N - 1 - j);
            if ((int'(a) / p) % 4 != (int'(b) / p) % 4) return j + 2;
        end
`endif
        return N + 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int acceptEdge);
        exp_t e;
        opA   = a;
        opB   = b;
        start = 1'b1;
        e.res      = refResult(a, b);
        e.accept   = acceptEdge;
        e.doneEdge = acceptEdge + expLatency(a, b) - 1;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic runOne(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(posedge clk); #1;
        applyStimulus(a, b, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        opA   = WIDTH'($urandom);
        opB   = WIDTH'($urandom);
        waitDrain(40);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: compares busy, held results and each done pulse against the scoreboard.
    initial begin
        forever begin
            logic expBusy;
            exp_t e;
            @(negedge clk);
            expBusy = (sb.size() > 0) && (cyc >= sb[0].accept) && (cyc < sb[0].doneEdge);
            checkOutput("busy", int'(busy), int'(expBusy));
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_edge", cyc, e.doneEdge);
                    checkOutput("result", int'({less, greater, equal}), int'(e.res));
                    expHeld = e.res;
                end
            end else begin
                checkOutput("held_result", int'({less, greater, equal}), int'(expHeld));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        idleCycles(2);
        #1;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_result", int'({less, greater, equal}), 0);
        rst = 1'b0;

        runOne(8'hA5, 8'hA5);
        runOne(8'h80, 8'h7F);
        runOne(8'h12, 8'h13);

        // A second start during SCAN must be ignored.
        @(posedge clk); #1;
        applyStimulus(8'hA5, 8'hA5, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        opA   = 8'h00;
        opB   = 8'hFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDrain(40);
        idleCycles(8);

        // Reset in the second cycle of a compare aborts it with no done pulse.
        @(posedge clk); #1;
        applyStimulus(8'h12, 8'h13, cyc + 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        expHeld = 3'b000;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_result", int'({less, greater, equal}), 0);
        idleCycles(2);
        #1;
        rst = 1'b0;
        idleCycles(8);
        runOne(8'h03, 8'h01);

        // Start held high across three back-to-back compares.
        @(posedge clk); #1;
        k = cyc + 1;
        applyStimulus(8'h10, 8'h20, k);
        lat = expLatency(8'h10, 8'h20);
        while (cyc < k) begin @(posedge clk); #1; end
        k = k + lat + 1;
        applyStimulus(8'h20, 8'h10, k);
        lat = expLatency(8'h20, 8'h10);
        while (cyc < k) begin @(posedge clk); #1; end
        k = k + lat + 1;
        applyStimulus(8'h33, 8'h33, k);
        while (cyc < k) begin @(posedge clk); #1; end
        start = 1'b0;
        waitDrain(40);

        for (int i = 0; i < 30; i++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            runOne(a, b);
            idleCycles($urandom_range(0, 3));
        end

        idleCycles(4);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
